// File: rtl/conv_sa_out_deskew_pkg.sv
// Shared defaults and helpers for the systolic-array output deskew block.
package conv_sa_out_deskew_pkg;

  localparam int DEFAULT_P  = 4;
  localparam int DEFAULT_DW = 32;

  // Lane i lags lane 0 by i cycles, so it needs p-1-i cycles of delay to line up with the last lane.
  function automatic int lane_delay(input int p, input int lane);
    return p - 1 - lane;
  endfunction

endpackage

// File: rtl/sa_out_fifo.sv
// First-word-fall-through row FIFO with registered almost-full and sticky overflow.
module sa_out_fifo #(
  parameter int WIDTH    = 256,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_data,
  output logic             afull,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;
  logic             afull_q;
  logic             ovf_q;

  assign rd_vld  = (count != '0);
  assign pop     = rd_vld && rd_rdy;
  // A full FIFO can still take a row when the head leaves in the same cycle.
  assign push    = wr_en && ((count < CW'(DEPTH)) || pop);
  assign rd_data = mem[rd_ptr];
  assign afull   = afull_q;
  assign ovf     = ovf_q;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      afull_q <= (count_nxt >= CW'(AF_LEVEL));
      if (wr_en && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/shift_reg.sv
// Fixed-length delay line; DELAY=0 is a plain wire, optional synchronous clear of all stages.
module shift_reg #(
  parameter int DELAY      = 1,
  parameter int DATA_WIDTH = 1,
  parameter bit USE_CLR    = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  if (DELAY == 0) begin : g_wire
    logic unused_clr;
    assign unused_clr = clr;
    assign q = d;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] stage [DELAY];

    always_ff @(posedge clk) begin
      if (USE_CLR && clr) begin
        for (int k = 0; k < DELAY; k++) stage[k] <= '0;
      end else begin
        stage[0] <= d;
        for (int k = 1; k < DELAY; k++) stage[k] <= stage[k-1];
      end
    end

    assign q = stage[DELAY-1];
  end

endmodule

// File: rtl/conv_sa_out_deskew.sv
// Realigns the staggered psum lanes of each array row and buffers whole rows for a valid/ready consumer.
module conv_sa_out_deskew
  import conv_sa_out_deskew_pkg::*;
#(
  parameter int P          = DEFAULT_P,
  parameter int DW         = DEFAULT_DW,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = P + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [P*DW-1:0] in_y1,
  input  logic [P*DW-1:0] in_y2,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [P*DW-1:0] out_y1,
  output logic [P*DW-1:0] out_y2,
  output logic          afull,
  output logic          ovf
);

  logic [P*DW-1:0]   y1_al;
  logic [P*DW-1:0]   y2_al;
  logic              wr_en;
  logic [2*P*DW-1:0] rd_data;

  for (genvar i = 0; i < P; i++) begin : g_lane
    shift_reg #(
      .DELAY      (lane_delay(P, i)),
      .DATA_WIDTH (DW),
      .USE_CLR    (1'b0)
    ) u_y1 (
      .clk (clk),
      .clr (1'b0),
      .d   (in_y1[i*DW +: DW]),
      .q   (y1_al[i*DW +: DW])
    );

    shift_reg #(
      .DELAY      (lane_delay(P, i)),
      .DATA_WIDTH (DW),
      .USE_CLR    (1'b0)
    ) u_y2 (
      .clk (clk),
      .clr (1'b0),
      .d   (in_y2[i*DW +: DW]),
      .q   (y2_al[i*DW +: DW])
    );
  end

  // Valid travels with lane 0 so it must be cleared on reset to drop rows still in flight.
  shift_reg #(
    .DELAY      (P - 1),
    .DATA_WIDTH (1),
    .USE_CLR    (1'b1)
  ) u_vld (
    .clk (clk),
    .clr (rst),
    .d   (in_vld),
    .q   (wr_en)
  );

  sa_out_fifo #(
    .WIDTH    (2 * P * DW),
    .DEPTH    (FIFO_DEPTH),
    .AF_LEVEL (FIFO_DEPTH - AF_MARGIN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({y2_al, y1_al}),
    .rd_vld  (out_vld),
    .rd_rdy  (out_rdy),
    .rd_data (rd_data),
    .afull   (afull),
    .ovf     (ovf)
  );

  assign out_y1 = rd_data[P*DW-1:0];
  assign out_y2 = rd_data[2*P*DW-1:P*DW];

endmodule

// File: doc/conv_sa_out_deskew.md
Name: conv_sa_out_deskew

Overview:
Output-side counterpart of the input-skewed systolic array. The array emits psum lanes staggered by one cycle per lane: lane i of a row appears i cycles after lane 0. This block realigns each row into a single wide word and buffers the rows in a small synchronous FIFO. It presents them downstream with a valid/ready handshake and raises almost-full back to the scheduler, because the array itself cannot stall.

Parameters:
P, `P, number of output lanes (array columns); at least 2.
DW, 32, bits per psum lane.
FIFO_DEPTH, 16, rows buffered; power of two; must be greater than AF_MARGIN.
AF_MARGIN, P+2, free-slot headroom covering rows still in flight in the array and the deskew stage.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_vld  in  1  row valid, aligned with lane 0 of the row
in_y1  in  P*DW  skewed psums, stream 1; lane i occupies bits [i*DW+:DW]
in_y2  in  P*DW  skewed psums, stream 2; same lane layout as in_y1
out_vld  out  1  aligned row available
out_rdy  in  1  downstream accepts the row
out_y1  out  P*DW  aligned row, stream 1
out_y2  out  P*DW  aligned row, stream 2
afull  out  1  FIFO count >= FIFO_DEPTH-AF_MARGIN; scheduler stops issuing rows
ovf  out  1  sticky overflow error

Behaviour:
- Deskew: lane i of in_y1/in_y2 is delayed P-1-i cycles. Lane P-1 has zero delay; lane 0 has P-1 cycles of delay.
- in_vld is delayed P-1 cycles to give the aligned write enable wr_en.
- If in_vld is high at cycle t0, the aligned row is complete at cycle t0+P-1 and is written into the FIFO on that edge.
- Latency: with an empty FIFO, out_vld rises at t0+P. The row data is on out_y1/out_y2 in that same cycle.
- Throughput: one row per cycle. Rows may be back-to-back (in_vld high for consecutive cycles).
- FIFO is first-word-fall-through, and out_y1/out_y2 are driven from the head entry.
  - Pop happens when out_vld && out_rdy.
  - out_y* must hold stable while out_vld && !out_rdy.
- Write accept rule: the write is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle (full, simultaneous read and write).
- Full case: when full with no pop, the write is dropped and ovf is set. ovf stays high until rst. The count and pointers are unchanged.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- afull is registered. It equals count >= FIFO_DEPTH-AF_MARGIN, evaluated on the next-state count.
- Reset values: out_vld=0, afull=0, ovf=0, count=0, both pointers=0, and the whole in_vld delay line cleared.
  - Deskew data registers and FIFO storage are not reset.
  - out_y* are don't-care while out_vld=0.
- Reset mid-operation: all rows in flight in the deskew stage and all buffered rows are discarded. No write occurs for rows whose in_vld was sampled before rst.
- Widths: data is passed through unmodified; no arithmetic on psums.

Decomposition:
- Shared package/include holds the DW default (32) and the lane slice macro.
- Per-lane delay reuses the existing shift_reg module (DELAY=P-1-i, DATA_WIDTH=DW), one instance per lane per stream.
- The in_vld delay line also uses shift_reg, with DATA_WIDTH=1 plus a synchronous clear, or is implemented locally.
- One natural sub-module, sa_out_fifo: a synchronous FWFT FIFO of width 2*P*DW with the count, afull and ovf logic.

Test Plan:
All scenarios use P=4, FIFO_DEPTH=16, AF_MARGIN=6.
1. Single row: drive lane i of in_y1 = 0x100+i and lane i of in_y2 = 0x200+i at cycle t0+i, with in_vld high at t0 only, and out_rdy=1 -> out_vld high only at t0+4, out_y1 = {0x103,0x102,0x101,0x100}, out_y2 = {0x203,…,0x200}.
2. Back-to-back: 20 consecutive rows whose lane values encode the row index, out_rdy=1 -> 20 in-order rows on consecutive cycles starting t0+4, with no gaps and ovf=0.
3. Backpressure and afull: out_rdy=0 while 10 rows are written -> afull rises the cycle after the 10th write; out_y* hold row 0 stable throughout.
4. Overflow: out_rdy=0 while 17 rows are written -> count=16, the 17th row is dropped, ovf=1 and stays 1. Then out_rdy=1 -> exactly rows 0..15 emerge in order.
5. Full with simultaneous read and write: FIFO full, out_rdy=1, new row arrives -> head popped, new row stored, count stays 16, ovf stays 0.
6. Reset mid-operation: rst pulsed 2 cycles after in_vld while 3 rows are buffered -> out_vld=0, afull=0, ovf=0 the next cycle, and the in-flight row never appears.
